exc_ctrl: RTL

EXC_CTRL -- requirements
Module: exc_ctrl

---
 rtl/exc_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/exc_ctrl.sv
// Commit-stage exception/interrupt controller: prioritises causes, writes CP0, redirects fetch.
// Optional event counters are built when EXC_CTRL_COUNTERS_EN is defined.
module exc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        cm_valid,
  input  logic [31:0] cm_pc,
  input  logic        cm_bd,
  input  logic [9:0]  cm_exc,
  input  logic        cm_tlb_store,
  input  logic        cm_refill,
  input  logic        cm_eret,
  input  logic [31:0] cm_daddr,
  input  logic        interrupt_pending,
  input  logic [31:0] epc,
  input  logic [31:0] exc_handler,
  input  logic [31:0] int_handler,
  input  logic [31:0] tlb_refill_handler,
  output logic        en_exp_o,
  output logic        ewr_bd,
  output logic [31:0] ewr_epc,
  output logic [31:0] ewr_badVAddr,
  output logic [4:0]  ewr_excCode,
  output logic        flush_o,
  output logic        stall_o,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic [31:0] exc_count,
  output logic [31:0] int_count
);

  localparam logic [0:0] StIdle     = 1'b0;
  localparam logic [0:0] StRedirect = 1'b1;

  localparam logic [4:0] ExcInt  = 5'd0;
  localparam logic [4:0] ExcMod  = 5'd1;
  localparam logic [4:0] ExcTlbl = 5'd2;
  localparam logic [4:0] ExcTlbs = 5'd3;
  localparam logic [4:0] ExcAdel = 5'd4;
  localparam logic [4:0] ExcAdes = 5'd5;
  localparam logic [4:0] ExcSys  = 5'd8;
  localparam logic [4:0] ExcBp   = 5'd9;
  localparam logic [4:0] ExcRi   = 5'd10;
  localparam logic [4:0] ExcOv   = 5'd12;
  // ERET has no architectural ExcCode; an otherwise unused encoding marks it for CP0.
  localparam logic [4:0] ExcEret = 5'd31;

  logic [0:0]  state_q;
  logic        en_exp_q, flush_q, bd_q;
  logic [31:0] epc_q, bad_q, rpc_q;
  logic [4:0]  code_q;

  logic        exc_event, is_int, is_eret;
  logic [4:0]  code_d;
  logic [31:0] bad_d, rpc_d;

  assign exc_event = (state_q == StIdle) && cm_valid &&
                     (interrupt_pending || (|cm_exc) || cm_eret);

  always_comb begin
    code_d  = ExcInt;
    bad_d   = 32'h0;
    rpc_d   = exc_handler;
    is_int  = 1'b0;
    is_eret = 1'b0;
    if (interrupt_pending) begin
      code_d = ExcInt;
      rpc_d  = int_handler;
      is_int = 1'b1;
    end else if (cm_exc[0]) begin
      code_d = ExcAdel;
      bad_d  = cm_pc;
    end else if (cm_exc[1]) begin
      code_d = ExcTlbl;
      bad_d  = cm_pc;
      rpc_d  = cm_refill ? tlb_refill_handler : exc_handler;
    end else if (cm_exc[2]) begin
      code_d = ExcRi;
    end else if (cm_exc[3]) begin
      code_d = ExcOv;
    end else if (cm_exc[4]) begin
      code_d = ExcSys;
    end else if (cm_exc[5]) begin
      code_d = ExcBp;
    end else if (cm_exc[6]) begin
      code_d = ExcAdel;
      bad_d  = cm_daddr;
    end else if (cm_exc[7]) begin
      code_d = ExcAdes;
      bad_d  = cm_daddr;
    end else if (cm_exc[8]) begin
      code_d = cm_tlb_store ? ExcTlbs : ExcTlbl;
      bad_d  = cm_daddr;
      rpc_d  = cm_refill ? tlb_refill_handler : exc_handler;
    end else if (cm_exc[9]) begin
      code_d = ExcMod;
      bad_d  = cm_daddr;
    end else if (cm_eret) begin
      code_d  = ExcEret;
      rpc_d   = epc;
      is_eret = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      en_exp_q <= 1'b0;
      flush_q  <= 1'b0;
      bd_q     <= 1'b0;
      epc_q    <= 32'h0;
      bad_q    <= 32'h0;
      code_q   <= 5'h0;
      rpc_q    <= 32'h0;
    end else begin
      en_exp_q <= 1'b0;
      flush_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (exc_event) begin
            state_q  <= StRedirect;
            en_exp_q <= 1'b1;
            flush_q  <= 1'b1;
            bd_q     <= cm_bd;
            epc_q    <= cm_bd ? (cm_pc - 32'd4) : cm_pc;
            bad_q    <= bad_d;
            code_q   <= code_d;
            rpc_q    <= rpc_d;
          end
        end
        StRedirect: begin
          if (redirect_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign en_exp_o       = en_exp_q;
  assign flush_o        = flush_q;
  assign ewr_bd         = bd_q;
  assign ewr_epc        = epc_q;
  assign ewr_badVAddr   = bad_q;
  assign ewr_excCode    = code_q;
  assign redirect_pc    = rpc_q;
  assign redirect_valid = (state_q == StRedirect);
  assign stall_o        = (state_q == StRedirect);

`ifdef EXC_CTRL_COUNTERS_EN
  logic [31:0] exc_cnt_q, int_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exc_cnt_q <= 32'h0;
      int_cnt_q <= 32'h0;
    end else if (exc_event) begin
      if (is_int) int_cnt_q <= int_cnt_q + 32'd1;
      else if (!is_eret) exc_cnt_q <= exc_cnt_q + 32'd1;
    end
  end

  assign exc_count = exc_cnt_q;
  assign int_count = int_cnt_q;
`else
  assign exc_count = 32'h0;
  assign int_count = 32'h0;
`endif

endmodule
